// File: rtl/sw_input_cond.sv
// Stopwatch input conditioning: synchronise and debounce the four board inputs,
// then turn the pause button into a run/hold toggle and reset into a pulse.
module sw_input_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic RESET,
  input  logic BTN_PAUSE,
  input  logic BTN_RESET,
  input  logic SW_ADJ,
  input  logic SW_SEL,
  output logic PAUSE,
  output logic RST_CMD,
  output logic ADJ,
  output logic SEL
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] raw;
  logic [3:0] synced;
  logic [3:0] stable_q;
  logic [3:0] accept;

  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [CNT_W-1:0]       cnt_q  [4];

  logic pause_q;
  logic rst_cmd_q;
  logic press_p;
  logic press_r;

  // Channel order: 0 pause, 1 reset, 2 adj, 3 sel
  assign raw = {SW_SEL, SW_ADJ, BTN_RESET, BTN_PAUSE};

  always_comb begin
    synced = '0;
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
      accept[i] = (synced[i] != stable_q[i]) &&
                  (cnt_q[i] == CNT_MAX);
    end
  end

  // A press is an accept edge whose new stable level is 1
  assign press_p = accept[0] & synced[0];
  assign press_r = accept[1] & synced[1];

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q  <= '0;
      pause_q   <= 1'b0;
      rst_cmd_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (synced[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          stable_q[i] <= synced[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      rst_cmd_q <= press_r;
      // A user reset always leaves the stopwatch running
      if (press_r) begin
        pause_q <= 1'b0;
      end else if (press_p) begin
        pause_q <= ~pause_q;
      end
    end
  end

  assign PAUSE   = pause_q;
  assign RST_CMD = rst_cmd_q;
  assign ADJ     = stable_q[2];
  assign SEL     = stable_q[3];

endmodule

// File: tb/tb_sw_input_cond.sv
// Directed bench for sw_input_cond with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sw_input_cond;

  logic clk = 1'b0;
  logic RESET;
  logic BTN_PAUSE;
  logic BTN_RESET;
  logic SW_ADJ;
  logic SW_SEL;
  logic PAUSE;
  logic RST_CMD;
  logic ADJ;
  logic SEL;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sw_input_cond #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .BTN_PAUSE(BTN_PAUSE),
    .BTN_RESET(BTN_RESET),
    .SW_ADJ(SW_ADJ),
    .SW_SEL(SW_SEL),
    .PAUSE(PAUSE),
    .RST_CMD(RST_CMD),
    .ADJ(ADJ),
    .SEL(SEL)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    BTN_PAUSE = 1'b0;
    BTN_RESET = 1'b0;
    SW_ADJ    = 1'b0;
    SW_SEL    = 1'b0;

    // 1: reset state and idle
    tick(3);
    chk("rst_pause", {3'b0, PAUSE}, 4'b0);
    chk("rst_rstcmd", {3'b0, RST_CMD}, 4'b0);
    chk("rst_adj", {3'b0, ADJ}, 4'b0);
    chk("rst_sel", {3'b0, SEL}, 4'b0);
    RESET = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk("idle", {PAUSE, RST_CMD, ADJ, SEL}, 4'b0);
    end

    // 2: SEL latency both directions
    SW_SEL = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("sel_rise", {3'b0, SEL}, {3'b0, k == 6});
    end
    SW_SEL = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("sel_fall", {3'b0, SEL}, {3'b0, k < 6});
    end
    tick(2);

    // 3: bouncy pause press, then release, then clean press
    BTN_PAUSE = 1'b1; tick(1);
    BTN_PAUSE = 1'b0; tick(1);
    BTN_PAUSE = 1'b1; tick(1);
    BTN_PAUSE = 1'b0; tick(1);
    BTN_PAUSE = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("pause_bounce", {3'b0, PAUSE}, {3'b0, k >= 6});
    end
    BTN_PAUSE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("pause_release", {3'b0, PAUSE}, 4'b0001);
    end
    BTN_PAUSE = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("pause_press2", {3'b0, PAUSE}, {3'b0, k < 6});
    end
    BTN_PAUSE = 1'b0;
    tick(10);
    BTN_PAUSE = 1'b1;
    tick(6);
    chk("pause_press3", {3'b0, PAUSE}, 4'b0001);
    BTN_PAUSE = 1'b0;
    tick(10);
    chk("pause_hold", {3'b0, PAUSE}, 4'b0001);

    // 4: held reset button gives one pulse and clears PAUSE
    BTN_RESET = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk("rstcmd_pulse", {3'b0, RST_CMD}, {3'b0, k == 6});
      chk("rstcmd_pause", {3'b0, PAUSE}, {3'b0, k < 6});
    end
    BTN_RESET = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("rstcmd_rel", {3'b0, RST_CMD}, 4'b0);
    end

    // 5: simultaneous pause and reset presses
    BTN_PAUSE = 1'b1;
    BTN_RESET = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk("simul_rstcmd", {3'b0, RST_CMD}, {3'b0, k == 6});
      chk("simul_pause", {3'b0, PAUSE}, 4'b0);
    end
    BTN_PAUSE = 1'b0;
    BTN_RESET = 1'b0;
    tick(10);

    // 6: system reset discards a count in progress
    SW_ADJ = 1'b1;
    tick(4);
    chk("adj_pre", {3'b0, ADJ}, 4'b0);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("adj_rst", {PAUSE, RST_CMD, ADJ, SEL}, 4'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("adj_after", {3'b0, ADJ}, {3'b0, k == 6});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
